// File: rtl/rr_stream_mux.sv
// rr_stream_mux: N-channel, W-bit valid/ready stream multiplexer with a fair
// round-robin arbiter and a single registered output stage (no skid buffer).
// Optional feature macro: MUX_PKT_LOCK_EN. When defined, it adds the in_last
// and out_last ports and a packet-lock FSM that keeps the grant on one channel
// until that channel's end-of-packet beat has been transferred.
module rr_stream_mux #(
  parameter  int N  = 4,
  parameter  int W  = 8,
  localparam int GW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [GW-1:0]  out_grant
`ifdef MUX_PKT_LOCK_EN
  ,
  input  logic [N-1:0]   in_last,
  output logic           out_last
`endif
);

  localparam int unsigned NU = N;

  logic [GW-1:0] ptr;
  logic          load_en;
  logic          found;
  logic [GW-1:0] g;
  logic [GW-1:0] g_inc;
  logic          xfer;
  logic [N-1:0]  eligible;
  logic          pkt_end;
  int unsigned   idx;
  logic [GW-1:0] gi;

  // Output register may load when empty or being drained; reset blocks all grants.
  always_comb begin
    load_en = (!out_valid || out_ready) && !rst;
  end

  // Round-robin scan starting at ptr, wrapping modulo N, over eligible channels.
  always_comb begin
    found = 1'b0;
    g     = '0;
    idx   = 0;
    gi    = '0;
    for (int unsigned k = 0; k < NU; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= NU) idx = idx - NU;
      gi = GW'(idx);
      if (!found && in_valid[gi] && eligible[gi]) begin
        found = 1'b1;
        g     = gi;
      end
    end
  end

  // Handshake decode and next pointer value after the winner.
  always_comb begin
    xfer     = load_en && found;
    in_ready = '0;
    if (xfer) in_ready[g] = 1'b1;
    g_inc = (32'(g) == NU - 1) ? '0 : g + 1'b1;
  end

`ifdef MUX_PKT_LOCK_EN
  typedef enum logic {IDLE, LOCKED} state_t;

  state_t        state, state_nxt;
  logic [GW-1:0] lock_ch, lock_ch_nxt;

  // Packet-lock state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      lock_ch <= '0;
    end else begin
      state   <= state_nxt;
      lock_ch <= lock_ch_nxt;
    end
  end

  // Lock on a non-final beat, release when the final beat transfers.
  always_comb begin
    state_nxt   = state;
    lock_ch_nxt = lock_ch;
    if (xfer) begin
      if (in_last[g]) begin
        state_nxt = IDLE;
      end else begin
        state_nxt   = LOCKED;
        lock_ch_nxt = g;
      end
    end
  end

  // While locked only the owning channel may compete; pointer moves on packet end.
  always_comb begin
    eligible = '1;
    if (state == LOCKED) begin
      eligible          = '0;
      eligible[lock_ch] = 1'b1;
    end
    pkt_end = in_last[g];
  end

  // Registered end-of-packet flag travelling with the beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_last <= 1'b0;
    end else if (xfer) begin
      out_last <= in_last[g];
    end
  end
`else
  // Without packet lock every beat is arbitrated on its own.
  always_comb begin
    eligible = '1;
    pkt_end  = 1'b1;
  end
`endif

  // Output register and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_grant <= '0;
      ptr       <= '0;
    end else if (load_en) begin
      if (found) begin
        out_data  <= in_data[g*W +: W];
        out_valid <= 1'b1;
        out_grant <= g;
        if (pkt_end) ptr <= g_inc;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
